inst_fetch_buf: RTL and testbench

Instruction-fetch front end between `inst_rom` and the decode stage of the Sirius core. It owns the fetch PC, drives the ROM chip-enable and address, and captures each returned instruction with its PC into a small prefetch FIFO. Decode pops that FIFO under a stall handshake, and a taken branch redirects fetch and flushes the FIFO. It replaces the bare PC register in the core's fetch path.

---
 rtl/inst_fetch_buf_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_fetch_buf.sv | 76 +++++++
 tb/tb_inst_fetch_buf.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_buf_pkg.sv
// Shared widths and constants for the Sirius fetch front end.
package inst_fetch_buf_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [InstBus-1:0]     ZeroWord    = '0;
    localparam logic                   ChipEnable  = 1'b1;
    localparam logic                   ChipDisable = 1'b0;
    localparam int unsigned            FetchBufDepth = 4;
    localparam logic [InstAddrBus-1:0] PcStep      = 32'd4;

    localparam int unsigned EntryW = InstAddrBus + InstBus;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a flush that clears pointers and count.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch PC owner: drives the instruction ROM and buffers {pc, inst} pairs for decode.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int unsigned            DEPTH    = FetchBufDepth,
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [InstBus-1:0]     rom_data_i,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   id_valid_o,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                   ce_en_q, ce_en_d;
    logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]        count;
    logic                   can_fetch, push, pop;
    fetch_entry_t           wentry, rentry;

    // A pop frees a slot in the same cycle, so a full FIFO still fetches when decode drains.
    always_comb begin
        id_valid_o = (count != '0);
        pop        = id_valid_o & ~stall_i;
        can_fetch  = (count < CntW'(DEPTH)) | pop;
        rom_ce_o   = ce_en_q ? (can_fetch ? ChipEnable : ChipDisable) : ChipDisable;
        rom_addr_o = rom_ce_o ? fetch_pc_q : ZeroWord;
        push       = ce_en_q & ~branch_flag_i & can_fetch;

        wentry.pc   = fetch_pc_q;
        wentry.inst = rom_data_i;
        id_pc_o     = rentry.pc;
        id_inst_o   = rentry.inst;

        ce_en_d    = 1'b1;
        fetch_pc_d = fetch_pc_q;
        if (branch_flag_i) begin
            fetch_pc_d = branch_target_i;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PcStep;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_en_q    <= 1'b0;
            fetch_pc_q <= RESET_PC;
        end else begin
            ce_en_q    <= ce_en_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_flag_i),
        .wdata (wentry),
        .rdata (rentry),
        .count (count)
    );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf against a queue-based reference model.
module tb_inst_fetch_buf;

    localparam int Depth = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        rom_ce, id_valid;
    logic [31:0] rom_addr, rom_data, id_pc, id_inst;

    logic        rst2;
    logic        rom_ce2, id_valid2;
    logic [31:0] rom_addr2, rom_data2, id_pc2, id_inst2;

    logic [31:0] salt;
    int          n_pass = 0;
    int          n_total = 0;

    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_ce;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    assign rom_data  = rom_ce  ? rom_word(rom_addr)  : 32'h0;
    assign rom_data2 = rom_ce2 ? rom_word(rom_addr2) : 32'h0;

    inst_fetch_buf dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_data),
        .stall_i         (stall),
        .branch_flag_i   (br),
        .branch_target_i (tgt),
        .id_valid_o      (id_valid),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst)
    );

    inst_fetch_buf #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk             (clk),
        .rst             (rst2),
        .rom_ce_o        (rom_ce2),
        .rom_addr_o      (rom_addr2),
        .rom_data_i      (rom_data2),
        .stall_i         (1'b0),
        .branch_flag_i   (1'b0),
        .branch_target_i (32'h0),
        .id_valid_o      (id_valid2),
        .id_pc_o         (id_pc2),
        .id_inst_o       (id_inst2)
    );

    logic [97:0] got_vec;
    assign got_vec = {rom_ce, rom_addr, id_valid, id_pc, id_inst};

    // Expected {rom_ce, rom_addr, id_valid, id_pc, id_inst} from the model for current inputs.
    function automatic logic [97:0] exp_vec();
        logic pop, ce;
        logic [63:0] head;
        pop  = (m_q.size() != 0) && !stall;
        ce   = m_ce && ((m_q.size() < Depth) || pop);
        head = (m_q.size() != 0) ? m_q[0] : 64'h0;
        return {ce, ce ? m_pc : 32'h0, m_q.size() != 0, head};
    endfunction

    function automatic void model_edge();
        logic pop, push;
        pop  = (m_q.size() != 0) && !stall;
        push = m_ce && !br && ((m_q.size() < Depth) || pop);
        if (br) begin
            m_q.delete();
            m_pc = tgt;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
    endfunction

    task automatic set_in(input logic s, input logic b, input logic [31:0] t);
        stall = s;
        br    = b;
        tgt   = t;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0);
        m_q.delete();
        m_pc = 32'h0;
        m_ce = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0);
        n_total++;
        if (got_vec !== 98'h0) $display("FAIL reset_outputs: got %h expected 0", got_vec);
        else n_pass++;
    endtask

    // Runs from cycle 0 after reset release, unstalled.
    task automatic startup_seq(input string tag);
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, 1'b0, 32'h0);
            n_total++;
            if (got_vec !== exp_vec())
                $display("FAIL %s_model c%0d: got %h expected %h", tag, c, got_vec, exp_vec());
            else n_pass++;
            if (c == 0) begin
                n_total++;
                if (rom_ce !== 1'b0) $display("FAIL %s_ce0: got %b expected 0", tag, rom_ce);
                else n_pass++;
            end else begin
                n_total++;
                if (rom_addr !== 32'(4 * (c - 1)))
                    $display("FAIL %s_addr c%0d: got %h expected %h", tag, c, rom_addr, 4*(c-1));
                else n_pass++;
            end
            if (c >= 2) begin
                n_total++;
                if (id_valid !== 1'b1 || id_pc !== 32'(4 * (c - 2))
                    || id_inst !== rom_word(32'(4 * (c - 2))))
                    $display("FAIL %s_id c%0d: got v=%b pc=%h inst=%h expected pc=%h",
                             tag, c, id_valid, id_pc, id_inst, 4*(c-2));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_startup();
        reset_dut();
        startup_seq("startup");
    endtask

    task automatic test_stall_fill();
        logic [31:0] next_pc;
        reset_dut();
        for (int c = 0; c < 9; c++) begin
            set_in(c >= 2, 1'b0, 32'h0);
            n_total++;
            if (got_vec !== exp_vec())
                $display("FAIL fill_model c%0d: got %h expected %h", c, got_vec, exp_vec());
            else n_pass++;
            advance();
        end
        set_in(1'b1, 1'b0, 32'h0);
        n_total++;
        if (rom_ce !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0)
            $display("FAIL fill_full: got ce=%b v=%b pc=%h expected ce=0 v=1 pc=0",
                     rom_ce, id_valid, id_pc);
        else n_pass++;
        next_pc = 32'h0;
        for (int c = 0; c < 10; c++) begin
            set_in(1'b0, 1'b0, 32'h0);
            n_total++;
            if (got_vec !== exp_vec())
                $display("FAIL drain_model c%0d: got %h expected %h", c, got_vec, exp_vec());
            else n_pass++;
            n_total++;
            if (id_pc !== next_pc)
                $display("FAIL drain_order c%0d: got %h expected %h", c, id_pc, next_pc);
            else n_pass++;
            next_pc = next_pc + 32'd4;
            advance();
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] a;
        reset_dut();
        for (int c = 0; c < 7; c++) begin
            set_in(1'b1, 1'b0, 32'h0);
            advance();
        end
        set_in(1'b0, 1'b0, 32'h0);
        a = rom_addr;
        n_total++;
        if (rom_ce !== 1'b1 || a !== 32'h10)
            $display("FAIL full_pop_fetch: got ce=%b addr=%h expected ce=1 addr=10", rom_ce, a);
        else n_pass++;
        advance();
        set_in(1'b1, 1'b0, 32'h0);
        n_total++;
        if (rom_ce !== 1'b0 || id_pc !== 32'h4 || got_vec !== exp_vec())
            $display("FAIL full_pop_still_full: got ce=%b pc=%h expected ce=0 pc=4", rom_ce, id_pc);
        else n_pass++;
        set_in(1'b0, 1'b0, 32'h0);
        n_total++;
        if (rom_addr !== a + 32'd4)
            $display("FAIL full_pop_addr_step: got %h expected %h", rom_addr, a + 32'd4);
        else n_pass++;
        advance();
    endtask

    task automatic test_branch();
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 1'b0, 32'h0);
            advance();
        end
        set_in(1'b1, 1'b1, 32'h100);
        n_total++;
        if (id_valid !== 1'b1 || got_vec !== exp_vec())
            $display("FAIL branch_pre: got %h expected %h", got_vec, exp_vec());
        else n_pass++;
        advance();
        set_in(1'b0, 1'b0, 32'h0);
        n_total++;
        if (id_valid !== 1'b0 || rom_addr !== 32'h100)
            $display("FAIL branch_k1: got v=%b addr=%h expected v=0 addr=100", id_valid, rom_addr);
        else n_pass++;
        advance();
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, 1'b0, 32'h0);
            n_total++;
            if (id_valid !== 1'b1 || id_pc !== 32'h100 + 32'(4 * c) || got_vec !== exp_vec())
                $display("FAIL branch_seq c%0d: got v=%b pc=%h expected v=1 pc=%h",
                         c, id_valid, id_pc, 32'h100 + 32'(4 * c));
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_random();
        int stall_pct;
        logic [31:0] t;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            stall_pct = ((c / 50) % 2 == 0) ? 20 : 75;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
            set_in($urandom_range(0, 99) < stall_pct, $urandom_range(0, 99) < 6, t);
            n_total++;
            if (got_vec !== exp_vec())
                $display("FAIL random_model c%0d: got %h expected %h", c, got_vec, exp_vec());
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 1'b0, 32'h0);
            advance();
        end
        set_in(1'b1, 1'b0, 32'h0);
        n_total++;
        if (id_valid !== 1'b1 || got_vec !== exp_vec())
            $display("FAIL async_pre: got %h expected %h", got_vec, exp_vec());
        else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_total++;
        if (got_vec !== 98'h0) $display("FAIL async_reset_outputs: got %h expected 0", got_vec);
        else n_pass++;
        m_q.delete();
        m_pc = 32'h0;
        m_ce = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        startup_seq("restart");
    endtask

    task automatic test_pc_wrap();
        logic [31:0] pcs [5];
        pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        @(negedge clk);
        rst2 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 0) begin
                n_total++;
                if (rom_ce2 !== 1'b0) $display("FAIL wrap_ce0: got %b expected 0", rom_ce2);
                else n_pass++;
            end else begin
                n_total++;
                if (rom_addr2 !== pcs[c-1])
                    $display("FAIL wrap_addr c%0d: got %h expected %h", c, rom_addr2, pcs[c-1]);
                else n_pass++;
            end
            if (c >= 2) begin
                n_total++;
                if (id_valid2 !== 1'b1 || id_pc2 !== pcs[c-2] || id_inst2 !== rom_word(pcs[c-2]))
                    $display("FAIL wrap_id c%0d: got pc=%h inst=%h expected pc=%h",
                             c, id_pc2, id_inst2, pcs[c-2]);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        rst2  = 1'b1;
        stall = 1'b0;
        br    = 1'b0;
        tgt   = 32'h0;
        salt  = $urandom;
        @(negedge clk);
        test_reset();
        test_startup();
        test_stall_fill();
        test_full_pop();
        test_branch();
        test_random();
        test_async_reset();
        test_pc_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
